// File: rtl/shifter_arbiter_if.sv
// Request/result bundle between four shift requesters, the arbiter and the result consumer.
interface shifter_arbiter_if #(
  parameter int N    = 8,
  parameter int LOGN = 3,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*N-1:0]    req_data;
  logic [NREQ*LOGN-1:0] req_amt;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic [N-1:0]         res_data;
  logic [1:0]           res_id;
  logic                 res_ready;

  modport master (
    output req_valid, req_data, req_amt, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );
  modport slave (
    input  req_valid, req_data, req_amt, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one combinational rotate-left barrel shifter
// among four requesters, with a single registered result slot.
module barrel_shifter #(
  parameter int N    = 8,
  parameter int LOGN = 3
) (
  input  logic [N-1:0]    in,
  input  logic [LOGN-1:0] sh_sel,
  output logic [N-1:0]    out
);
  logic [LOGN:0][N-1:0] st;

  assign st[0] = in;
  for (genvar k = 0; k < LOGN; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign st[k+1] = sh_sel[k] ? {st[k][N-1-SH:0], st[k][N-1:N-SH]} : st[k];
  end
  assign out = st[LOGN];
endmodule

module shifter_arbiter #(
  parameter int N    = 8,
  parameter int LOGN = 3,
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  shifter_arbiter_if.slave bus
);
  logic [1:0]      ptr_q, ptr_d;
  logic            res_valid_q, res_valid_d;
  logic [N-1:0]    res_data_q, res_data_d;
  logic [1:0]      res_id_q, res_id_d;

  logic [1:0]      gidx;
  logic            any_req, slot_free, xfer;
  logic [N-1:0]    sh_in, sh_out;
  logic [LOGN-1:0] sh_amt;

  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    gidx = ptr_q;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (bus.req_valid[ptr_q + 2'(k)]) gidx = ptr_q + 2'(k);
    end
  end

  assign any_req   = |bus.req_valid;
  assign slot_free = !res_valid_q || bus.res_ready;
  assign xfer      = any_req && slot_free && !rst;
  assign bus.req_ready = xfer ? (NREQ'(1) << gidx) : '0;

  assign sh_in  = bus.req_data[gidx*N +: N];
  assign sh_amt = bus.req_amt[gidx*LOGN +: LOGN];

  barrel_shifter #(.N(N), .LOGN(LOGN)) u_shifter (
    .in     (sh_in),
    .sh_sel (sh_amt),
    .out    (sh_out)
  );

  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    if (xfer) begin
      res_data_d  = sh_out;
      res_id_d    = gidx;
      res_valid_d = 1'b1;
      ptr_d       = gidx + 2'd1;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed vector table followed by randomized traffic against a behavioural model.
module tb_shifter_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shifter_arbiter_if #(.N(8), .LOGN(3), .NREQ(4)) bus ();
  shifter_arbiter #(.N(8), .LOGN(3), .NREQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] data;
    logic [11:0] amt;
    logic        rr;
    logic [3:0]  ready;
    logic        v;
    logic [7:0]  d;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl[$];
  int   ncmp = 0;
  int   nerr = 0;

  // behavioural model state
  logic       m_v;
  logic [7:0] m_d;
  logic [1:0] m_id;
  int         m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rv, input logic [31:0] d, input logic [11:0] a,
                     input logic rr, input logic [3:0] rdy, input logic v, input logic [7:0] rd,
                     input logic [1:0] id);
    vec_t e;
    e = '{r, rv, d, a, rr, rdy, v, rd, id};
    tbl.push_back(e);
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] d, input int a);
    int x;
    x = ((int'(d) << a) | (int'(d) >> (8 - a))) & 255;
    return 8'(x);
  endfunction

  task automatic drive(input logic r, input logic [3:0] rv, input logic [31:0] d,
                       input logic [11:0] a, input logic rr);
    rst = r; bus.req_valid = rv; bus.req_data = d; bus.req_amt = a; bus.res_ready = rr;
  endtask

  localparam logic [31:0] D0 = {8'h00, 8'h00, 8'h00, 8'h9D};
  localparam logic [11:0] A0 = {3'd0, 3'd0, 3'd0, 3'd7};
  localparam logic [31:0] DR = {8'h80, 8'h01, 8'h5B, 8'hE5};
  localparam logic [11:0] AR = {3'd1, 3'd0, 3'd3, 3'd1};

  initial begin
    drive(1'b1, 4'b0, 32'b0, 12'b0, 1'b0);

    // reset, single request
    add(1, 4'b0000, D0, A0, 0, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1111, DR, AR, 1, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0001, D0, A0, 1, 4'b0001, 1, 8'hCE, 0);
    add(0, 4'b0000, D0, A0, 1, 4'b0000, 0, 8'hCE, 0);
    // round robin
    add(1, 4'b0000, DR, AR, 1, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b1111, DR, AR, 1, 4'b0001, 1, 8'hCB, 0);
    add(0, 4'b1111, DR, AR, 1, 4'b0010, 1, 8'hDA, 1);
    add(0, 4'b1111, DR, AR, 1, 4'b0100, 1, 8'h01, 2);
    add(0, 4'b1111, DR, AR, 1, 4'b1000, 1, 8'h01, 3);
    add(0, 4'b1111, DR, AR, 1, 4'b0001, 1, 8'hCB, 0);
    // back-pressure for 3 cycles, then release
    add(0, 4'b1111, DR, AR, 0, 4'b0000, 1, 8'hCB, 0);
    add(0, 4'b1111, DR, AR, 0, 4'b0000, 1, 8'hCB, 0);
    add(0, 4'b1111, DR, AR, 0, 4'b0000, 1, 8'hCB, 0);
    add(0, 4'b1111, DR, AR, 1, 4'b0010, 1, 8'hDA, 1);
    // contention between 1 and 3 from ptr=2
    add(0, 4'b1010, DR, AR, 1, 4'b1000, 1, 8'h01, 3);
    add(0, 4'b1010, DR, AR, 1, 4'b0010, 1, 8'hDA, 1);
    add(0, 4'b1010, DR, AR, 1, 4'b1000, 1, 8'h01, 3);
    add(0, 4'b1010, DR, AR, 1, 4'b0010, 1, 8'hDA, 1);
    // reset while full with requests pending
    add(1, 4'b1111, DR, AR, 0, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b1100, DR, AR, 1, 4'b0100, 1, 8'h01, 2);
    // idle: ptr must stay at 3
    for (int i = 0; i < 5; i++) add(0, 4'b0000, DR, AR, 1, 4'b0000, 0, 8'h01, 2);
    add(0, 4'b1111, DR, AR, 1, 4'b1000, 1, 8'h01, 3);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].rv, tbl[i].data, tbl[i].amt, tbl[i].rr);
      #1 chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d res_valid", i), 32'(bus.res_valid), 32'(tbl[i].v));
      chk($sformatf("row%0d res_data", i), 32'(bus.res_data), 32'(tbl[i].d));
      chk($sformatf("row%0d res_id", i), 32'(bus.res_id), 32'(tbl[i].id));
    end

    // random traffic; first cycle is a reset so the model starts aligned
    m_v = 0; m_d = 0; m_id = 0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      logic        r, rr;
      logic [3:0]  rv, exp_rdy;
      logic [31:0] d;
      logic [11:0] a;
      int          g;
      r  = (c == 0) || ($urandom_range(0, 39) == 0);
      rv = 4'($urandom);
      d  = $urandom;
      a  = 12'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      drive(r, rv, d, a, rr);
      exp_rdy = 4'b0;
      g = -1;
      if (!r && (!m_v || rr)) begin
        for (int k = 3; k >= 0; k--)
          if (rv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        if (g >= 0) exp_rdy = 4'(1 << g);
      end
      #1 chk("rand req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      @(posedge clk);
      if (r) begin
        m_v = 0; m_d = 0; m_id = 0; m_ptr = 0;
      end else if (g >= 0) begin
        m_d   = rotl(d[g*8 +: 8], int'(a[g*3 +: 3]));
        m_id  = 2'(g);
        m_v   = 1;
        m_ptr = (g + 1) % 4;
      end else if (m_v && rr) begin
        m_v = 0;
      end
      #1;
      chk("rand res_valid", 32'(bus.res_valid), 32'(m_v));
      chk("rand res_data", 32'(bus.res_data), 32'(m_d));
      chk("rand res_id", 32'(bus.res_id), 32'(m_id));
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/shifter_arbiter.md
# shifter_arbiter

Round-robin arbiter that shares one combinational `barrel_shifter` instance among four requesters. Each requester presents a data word and a shift amount with a valid/ready handshake. The block grants one request per cycle, drives the shared shifter, and captures the result in a single registered output slot tagged with the winning requester's index. It sits between the requesting datapath units and the shifter, and is the only driver of the shifter's `in`/`sh_sel` inputs.

## Interface

- `N`, 8, data width; matches the shifter width.
- `LOGN`, 3, shift-amount width; must equal log2(N).
- `NREQ`, 4, number of requesters; fixed at 4, so `res_id` is 2 bits.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: bit i set means requester i presents a request.
- `req_data` input NREQ*N: requester i's word at bits [i*N +: N].
- `req_amt` input NREQ*LOGN: requester i's shift amount at bits [i*LOGN +: LOGN].
- `req_ready` output NREQ: one-hot or zero; the granted requester.
- `res_valid` output 1: output slot holds a result.
- `res_data` output N: rotated word.
- `res_id` output 2: index of the requester that produced `res_data`.
- `res_ready` input 1: consumer accepts the result.

## Operation

- **Shifter function:** the internal `barrel_shifter` rotates `in` left by `sh_sel` positions. Amount 0 passes the word through unchanged.
- **Slot state:** one output slot with two states.
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- **Slot free:** the slot is free when `!res_valid || res_ready`.
- **Grant rule (combinational):**
  - If the slot is free and any `req_valid` bit is set, assert `req_ready` for exactly one requester.
  - The winner is the first set `req_valid` bit found scanning upward from pointer `ptr`, modulo 4.
  - Otherwise `req_ready`=0.
  - `req_ready` never asserts for a requester whose `req_valid` is low.
- **Transfer:** occurs when `req_valid[g] && req_ready[g]`. On the next edge:
  - `res_data` <= rotl(`req_data[g]`, `req_amt[g]`)
  - `res_id` <= g
  - `res_valid` <= 1
  - `ptr` <= (g+1) mod 4
- **No transfer:**
  - If `res_valid && res_ready`, then `res_valid` <= 0.
  - Otherwise the slot holds. `res_data` and `res_id` stay stable while `res_valid`=1 and `res_ready`=0.
- **Simultaneous consume and grant:** the new result replaces the old one in the same edge. `res_valid` stays 1, giving full throughput of one result per cycle.
- **`ptr` update:** `ptr` advances only on a transfer. It never moves on idle cycles or back-pressured cycles.
- **Requester holding:** a requester whose `req_valid` is high but not granted holds its inputs. The arbiter does not latch unaccepted requests.
- **Fairness:** with all four requesting continuously and `res_ready`=1, grants follow 0,1,2,3,0,… Any requester waits at most 3 transfers.

## Timing

- **Reset** (synchronous: `rst` high at an edge):
  - `res_valid`=0, `res_data`=0, `res_id`=0, `ptr`=0.
  - `req_ready` is forced to 0 while `rst`=1.
- **Latency:** one cycle from transfer edge to `res_valid` high with the result.
- **Throughput:** one result per cycle while `res_ready`=1.
- **Reset mid-operation:** a result held in the slot is discarded. No request is accepted in the reset cycle. `ptr` returns to 0.
- **Back-pressure:**
  - `res_valid`=1 and `res_ready`=0 forces `req_ready`=0 in the same cycle.
  - The slot frees, and a grant is possible, in the cycle `res_ready` rises.
- **Combinational paths:**
  - `req_ready` depends combinationally on `req_valid`, `res_valid`, `res_ready` and `ptr`.
  - No combinational path from `req_*` to `res_*`.

## Test plan

- **Single request:** after reset, requester 0 presents 10011101 with amount 7 and `res_ready`=1.
  - Required: `req_ready`=0001 in the same cycle.
  - Required: next cycle `res_valid`=1, `res_data`=11001110, `res_id`=0.
- **Round-robin order:** all four requesters valid continuously with `res_ready`=1. Data and amounts:
  - 11100101, amount 1
  - 01011011, amount 3
  - 00000001, amount 0
  - 10000000, amount 1
  - Required: `res_id` sequence 0,1,2,3,0.
  - Required: `res_data` sequence 11001011, 11011010, 00000001, 00000001.
- **Back-pressure:** hold `res_ready`=0 for 3 cycles with requests pending.
  - Required: `req_ready`=0000 throughout, `res_data`/`res_id` stable, `ptr` unchanged.
  - Required: on `res_ready`=1, a grant in the same cycle and a new result on the next edge.
- **Fairness under contention:** requesters 1 and 3 valid continuously, `ptr`=2 after a prior grant to 1.
  - Required: grants 3,1,3,1.
- **Reset mid-operation:** assert `rst` for one cycle while `res_valid`=1 and a request is pending.
  - Required: next cycle `res_valid`=0, `res_data`=0, `req_ready`=0000 during reset.
  - Required: the first post-reset grant goes to the lowest-index valid requester.
- **Idle:** no `req_valid` for 5 cycles.
  - Required: `res_valid` drops after consumption and `ptr` is unchanged.
